bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter N, default 4: width of binary input.
REQ-002 SHALL have parameter D, default 2: number of BCD output digits.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port binary  input  N  unsigned value to convert (driven by upstream binary counter).
REQ-006 SHALL have port start  input  1  request; sampled on clk rising edge.
REQ-007 SHALL have port busy  output  1  conversion in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse; bcd valid.
REQ-009 SHALL have port bcd  output  4*D  packed BCD result; digit 0 in bits [3:0].

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-011 IDLE + start=1 at edge k: SHALL capture binary into shift register, clear BCD work register, clear step count, go to SHIFT; busy=1 after edge k.
REQ-012 SHIFT: SHALL do one double-dabble step per cycle: each work digit >=5 gets +3, then {work,shreg} shifts left 1, MSB of shreg enters digit 0 LSB.
REQ-013 SHALL stay in SHIFT exactly N cycles; after edge k+N: state DONE, busy=0, done=1, bcd=work register.
REQ-014 DONE SHALL last exactly one cycle, then IDLE; done=0.
REQ-015 bcd SHALL hold the last result until the next DONE, never showing intermediate values.
REQ-016 start while busy=1 SHALL be ignored, with no effect on the running conversion.
REQ-017 start=1 during the DONE cycle SHALL be accepted (back-to-back): capture binary, enter SHIFT, with done=1 still output for that cycle.
REQ-018 binary SHALL be sampled only at the accepting edge; later changes SHALL NOT affect the result.
REQ-019 Digits shifted beyond digit D-1 SHALL be discarded: bcd = binary mod 10^D.
REQ-020 Step counter width SHALL be clog2(N+1); N=1 SHALL work (1 shift cycle).

Reset
REQ-021 reset=0 SHALL asynchronously force IDLE, busy=0, done=0, bcd=0, internal registers 0.
REQ-022 Reset during SHIFT or DONE SHALL abort the conversion with no done pulse; the first start after release SHALL behave as from power-up.

Configuration
REQ-023 With macro BIN2BCD_SEQ_OVF_EN defined: SHALL add output port ovf (1 bit), cleared at start acceptance and at reset.
REQ-024 With BIN2BCD_SEQ_OVF_EN: ovf SHALL be sticky-set when any SHIFT step shifts a 1 out of the MSB of adjusted digit D-1, i.e. binary >= 10^D; valid with done and held like bcd.
REQ-025 Without BIN2BCD_SEQ_OVF_EN: no ovf port and no overflow logic; bcd behaviour identical.

Structure
REQ-026 Package bin2bcd_pkg SHALL hold the FSM state typedef (IDLE/SHIFT/DONE), BCD digit width constant 4, adjust threshold 5 and offset 3.
REQ-027 Sub-module bcd_digit_adj SHALL implement the combinational per-digit add-3 correction, instantiated D times via generate.

Verification
REQ-028 N=8,D=3: binary=255, start pulse -> busy high 8 cycles, then done 1 cycle, bcd=12'h255.
REQ-029 N=8,D=3: binary=0 -> bcd=12'h000 after 8 shift cycles; binary=99 -> bcd=12'h099.
REQ-030 N=8,D=2, OVF_EN: binary=200 -> bcd=8'h00, ovf=1; next binary=42 -> bcd=8'h42, ovf=0.
REQ-031 start=1 held continuously with binary incrementing 0..15 (N=4,D=2) -> one conversion per N+1 cycles, results 00,05,10,15 per captured value, no lost done pulses.
REQ-032 Reset asserted mid-SHIFT (N=8, binary=123) -> immediate busy=0, done=0, bcd=0; after release, conversion of 123 -> bcd=12'h123.
REQ-033 start pulsed during SHIFT with a different binary value -> ignored; result equals the originally captured value.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// bin2bcd_pkg: shared FSM state type and double-dabble constants
package bin2bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int DIGIT_W = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_OFFSET = 3;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: add-3 correction of one BCD digit before a double-dabble shift
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);
  assign o_digit = (i_digit >= DIGIT_W'(ADJ_THRESH)) ? i_digit + DIGIT_W'(ADJ_OFFSET) : i_digit;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Define BIN2BCD_SEQ_OVF_EN to add the sticky ovf output (binary >= 10^D).
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int N = 4,
  parameter int D = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     binary,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [4*D-1:0]   bcd
`ifdef BIN2BCD_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(N + 1);
  localparam int W = DIGIT_W * D;
  state_t r_state;
  logic [N-1:0] r_shreg;
  logic [W-1:0] r_work;
  logic [CW-1:0] r_cnt;
  logic [W-1:0] w_adj;
  logic [W-1:0] w_next;
  logic w_last;
  for (genvar i = 0; i < D; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit(r_work[i*DIGIT_W +: DIGIT_W]),
      .o_digit(w_adj[i*DIGIT_W +: DIGIT_W])
    );
  end
  // the MSB of the top adjusted digit falls off here: that is the mod 10^D truncation
  assign w_next = {w_adj[W-2:0], r_shreg[N-1]};
  assign w_last = r_cnt == CW'(N - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_work  <= '0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        SHIFT: begin
          r_work  <= w_next;
          r_shreg <= r_shreg << 1;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bcd     <= w_next;
          end
        end
        default: begin
          if (start) begin
            r_state <= SHIFT;
            r_shreg <= binary;
            r_work  <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end
`ifdef BIN2BCD_SEQ_OVF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf <= 1'b0;
    else if (r_state != SHIFT && start) ovf <= 1'b0;
    else if (r_state == SHIFT && w_adj[W-1]) ovf <= 1'b1;
  end
`else
  logic w_unused_msb;
  assign w_unused_msb = w_adj[W-1];
`endif
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: four converter instances checked every cycle against a
// transaction-level model (capture value, wait N cycles, expect value mod 10^D).
module tb_bin2bcd_seq;
  localparam int ND = 4;
  localparam int NN [ND] = '{8, 4, 8, 1};
  localparam int PW [ND] = '{1000, 100, 100, 10};
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic st [ND];
  logic [15:0] bin [ND];
  logic bz [ND];
  logic dn [ND];
  logic [11:0] bc [ND];
  logic [7:0] bcd_b, bcd_c;
  logic [3:0] bcd_d;
`ifdef BIN2BCD_SEQ_OVF_EN
  logic ov [ND];
`endif
  int n_chk = 0;
  int n_err = 0;
  int rem [ND];
  int val [ND];
  bit ed [ND];
  bit eo [ND];
  logic [11:0] eb [ND];

  always #5 clk = ~clk;

  assign bc[1] = {4'h0, bcd_b};
  assign bc[2] = {4'h0, bcd_c};
  assign bc[3] = {8'h00, bcd_d};

  bin2bcd_seq #(.N(8), .D(3)) u_a (
    .clk(clk), .reset(reset), .binary(bin[0][7:0]), .start(st[0]),
    .busy(bz[0]), .done(dn[0]), .bcd(bc[0])
`ifdef BIN2BCD_SEQ_OVF_EN
    , .ovf(ov[0])
`endif
  );
  bin2bcd_seq #(.N(4), .D(2)) u_b (
    .clk(clk), .reset(reset), .binary(bin[1][3:0]), .start(st[1]),
    .busy(bz[1]), .done(dn[1]), .bcd(bcd_b)
`ifdef BIN2BCD_SEQ_OVF_EN
    , .ovf(ov[1])
`endif
  );
  bin2bcd_seq #(.N(8), .D(2)) u_c (
    .clk(clk), .reset(reset), .binary(bin[2][7:0]), .start(st[2]),
    .busy(bz[2]), .done(dn[2]), .bcd(bcd_c)
`ifdef BIN2BCD_SEQ_OVF_EN
    , .ovf(ov[2])
`endif
  );
  bin2bcd_seq #(.N(1), .D(1)) u_d (
    .clk(clk), .reset(reset), .binary(bin[3][0:0]), .start(st[3]),
    .busy(bz[3]), .done(dn[3]), .bcd(bcd_d)
`ifdef BIN2BCD_SEQ_OVF_EN
    , .ovf(ov[3])
`endif
  );

  function automatic logic [11:0] to_bcd(int v);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [11:0] got, logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    for (int d = 0; d < ND; d++) begin
      if (!reset) begin
        rem[d] = 0;
        ed[d] = 1'b0;
        eb[d] = '0;
        eo[d] = 1'b0;
      end else if (rem[d] > 0) begin
        rem[d]--;
        ed[d] = rem[d] == 0;
        if (ed[d]) begin
          eb[d] = to_bcd(val[d] % PW[d]);
          eo[d] = val[d] >= PW[d];
        end
      end else begin
        ed[d] = 1'b0;
        if (st[d]) begin
          val[d] = int'(bin[d]) % (1 << NN[d]);
          rem[d] = NN[d];
          eo[d] = 1'b0;
        end
      end
    end
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("busy%0d", d), 12'(bz[d]), 12'(rem[d] > 0));
      chk($sformatf("done%0d", d), 12'(dn[d]), 12'(ed[d]));
      chk($sformatf("bcd%0d", d), bc[d], eb[d]);
`ifdef BIN2BCD_SEQ_OVF_EN
      if (rem[d] == 0) chk($sformatf("ovf%0d", d), 12'(ov[d]), 12'(eo[d]));
`endif
    end
  end

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(int d, int v);
    @(negedge clk);
    bin[d] = 16'(v);
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      st[d] = 1'b0;
      bin[d] = '0;
    end
    idle(3);
    reset = 1'b1;
    pulse(0, 255); idle(10);
    pulse(0, 0);   idle(10);
    pulse(0, 99);  idle(10);
    pulse(0, 77);  idle(3);
    pulse(0, 200); idle(10);
    pulse(2, 200); idle(10);
    pulse(2, 42);  idle(10);
    pulse(3, 1);   idle(3);
    pulse(3, 0);   idle(3);
    pulse(0, 123); idle(3);
    #2 reset = 1'b0;
    idle(1);
    reset = 1'b1;
    pulse(0, 123); idle(10);
    @(negedge clk);
    st[1] = 1'b1;
    for (int i = 0; i < 80; i++) begin
      bin[1] = 16'(i % 16);
      @(negedge clk);
    end
    st[1] = 1'b0;
    idle(6);
    repeat (3000) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        st[d] = $urandom_range(0, 2) == 0;
        bin[d] = 16'($urandom);
      end
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
    end
    for (int d = 0; d < ND; d++) st[d] = 1'b0;
    idle(20);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
